// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared pipeline types for the 5-stage CPU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [c_WORD_W-1:0] instr;
        logic [c_WORD_W-1:0] pc;
        logic [c_WORD_W-1:0] npc;
        logic                valid;
    } fd_bundle_t;

    // Instruction addresses are always word aligned.
    function automatic logic [c_WORD_W-1:0] word_align(input logic [c_WORD_W-1:0] addr);
        return {addr[c_WORD_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fd_latch.sv
// ============================================================================
// Module      : fd_latch
// Description : Generic pipeline register controlled by pipe_state_t, with
//               freeze (i_hold) and wrong-path squash inputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fd_latch
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_hold,
    input  pipe_state_t i_state,
    input  logic        i_load,
    input  logic        i_squash,
    input  fd_bundle_t  i_data,
    output fd_bundle_t  o_data
);

    fd_bundle_t r_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_q <= '0;
        end else if (i_hold) begin
            r_q <= r_q;
        end else begin
            case (i_state)
                PIPE_NOP:    r_q <= '0;
                PIPE_STALL:  r_q <= r_q;
                PIPE_ENABLE: begin
                    if (i_load) begin
                        r_q <= i_squash ? '0 : i_data;
                    end
                end
                default:     r_q <= r_q;
            endcase
        end
    end

    assign o_data = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: PC register, next-PC select, pending
//               redirect capture, halt handling and the IF/ID latch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              pc_wen,
    input  logic              redirect,
    input  logic [1:0]        pcsrc,
    input  logic [WORD_W-1:0] branch_target,
    input  logic [WORD_W-1:0] jump_target,
    input  logic [WORD_W-1:0] jr_addr,
    input  pipe_state_t       fd_state,
    input  logic              halt_in,
    output logic [WORD_W-1:0] d_instr,
    output logic [WORD_W-1:0] d_pc,
    output logic [WORD_W-1:0] d_npc,
    output logic              d_valid
);

    fetch_state_t      r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_pend_target;

    logic [WORD_W-1:0] w_pc_plus4;
    logic [WORD_W-1:0] w_target_raw;
    logic [WORD_W-1:0] w_target;
    logic              w_freeze;
    fd_bundle_t        w_fd_in;
    fd_bundle_t        w_fd_out;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target_raw = w_pc_plus4;
        case (pcsrc_t'(pcsrc))
            PC_NEXT:   w_target_raw = w_pc_plus4;
            PC_BRANCH: w_target_raw = branch_target;
            PC_JUMP:   w_target_raw = jump_target;
            PC_JR:     w_target_raw = jr_addr;
            default:   w_target_raw = w_pc_plus4;
        endcase
    end

    assign w_target = word_align(w_target_raw);

    // A halt seen this cycle already freezes everything on the coming edge.
    assign w_freeze = halt_in || (r_state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= FETCH;
            r_pc          <= word_align(PC_INIT);
            r_pend_target <= '0;
        end else if (w_freeze) begin
            r_state <= HALTED;
        end else begin
            case (r_state)
                FETCH: begin
                    if (pc_wen) begin
                        r_pc <= redirect ? w_target : w_pc_plus4;
                    end else if (redirect) begin
                        r_pend_target <= w_target;
                        r_state       <= REDIR_PEND;
                    end
                end
                REDIR_PEND: begin
                    if (pc_wen) begin
                        r_pc    <= redirect ? w_target : r_pend_target;
                        r_state <= FETCH;
                    end else if (redirect) begin
                        r_pend_target <= w_target;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign imemREN  = (r_state != HALTED);
    assign imemaddr = r_pc;

    assign w_fd_in = '{instr: iload, pc: r_pc, npc: w_pc_plus4, valid: 1'b1};

    // Fetches completing while a redirect is pending are wrong-path.
    fd_latch u_fd_latch (
        .CLK      (CLK),
        .nRST     (nRST),
        .i_hold   (w_freeze),
        .i_state  (fd_state),
        .i_load   (ihit),
        .i_squash (r_state == REDIR_PEND),
        .i_data   (w_fd_in),
        .o_data   (w_fd_out)
    );

    assign d_instr = w_fd_out.instr;
    assign d_pc    = w_fd_out.pc;
    assign d_npc   = w_fd_out.npc;
    assign d_valid = w_fd_out.valid;

endmodule

`default_nettype wire
